calc_alu_sequencer: RTL

- Multi-cycle arithmetic controller for the keypad calculator datapath.
- Accepts two signed operands plus the calculator's 4-bit operation code. Sequences a one-cycle add/sub, a shift-add multiply or a restoring divide.
- Returns a two's-complement result with overflow/error flags over a start/busy/done handshake.
- Sits between the operand/operator latching logic and the bin2dec display conversion, replacing the combinational `*` and `/`.

---
 rtl/calc_alu_sequencer.sv | 235 +++++++++++++++++++++++
 1 files changed

// File: rtl/calc_alu_sequencer.sv
// calc_alu_sequencer: multi-cycle arithmetic controller for the keypad
// calculator datapath. Add/sub complete in one working cycle. Multiply is
// a shift-add over operand magnitudes and divide is a restoring divide, each
// taking WIDTH iterations. The sign is applied in a final fix-up cycle.
module calc_alu_sequencer #(
    parameter int WIDTH = 10
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [3:0]       opcode,
    input  logic [WIDTH-1:0] operand_a,
    input  logic [WIDTH-1:0] operand_b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             ovf,
    output logic             err
);
    localparam int CW = $clog2(WIDTH + 1);
    localparam logic [3:0] OP_ADD = 4'd1;
    localparam logic [3:0] OP_SUB = 4'd2;
    localparam logic [3:0] OP_MUL = 4'd3;
    localparam logic [3:0] OP_DIV = 4'd4;
    localparam logic [CW-1:0] ITER_INIT = CW'(WIDTH);
    localparam logic [CW-1:0] ITER_LAST = CW'(1);
    localparam logic [WIDTH-1:0] ZERO_W = {WIDTH{1'b0}};
    localparam logic [WIDTH-1:0] ONE_W  = {{(WIDTH-1){1'b0}}, 1'b1};
    // Largest magnitude representable when negative (2^(WIDTH-1)) and positive.
    localparam logic [2*WIDTH-1:0] NEG_LIM = {{WIDTH{1'b0}}, 1'b1, {(WIDTH-1){1'b0}}};
    localparam logic [2*WIDTH-1:0] POS_LIM = NEG_LIM - {{(2*WIDTH-1){1'b0}}, 1'b1};

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_LOAD   = 3'd1,
        S_MUL_IT = 3'd2,
        S_DIV_IT = 3'd3,
        S_FIX    = 3'd4,
        S_DONE   = 3'd5
    } state_t;

    state_t             state_r;
    logic [3:0]         op_r;
    logic [WIDTH-1:0]   a_r;
    logic [WIDTH-1:0]   b_r;
    logic               neg_r;
    logic               is_div_r;
    logic [2*WIDTH-1:0] acc_r;
    logic [2*WIDTH-1:0] mcand_r;
    logic [WIDTH-1:0]   mplier_r;
    logic [WIDTH-1:0]   divisor_r;
    logic [WIDTH-1:0]   rem_r;
    logic [WIDTH-1:0]   quot_r;
    logic [CW-1:0]      iter_r;

    logic [WIDTH:0]     sum_s;
    logic [WIDTH:0]     diff_s;
    logic [WIDTH-1:0]   abs_a_s;
    logic [WIDTH-1:0]   abs_b_s;
    logic [WIDTH:0]     shifted_s;
    logic               fits_s;
    logic [WIDTH-1:0]   trial_s;
    logic [2*WIDTH-1:0] fix_mag_s;
    logic               fix_ovf_s;
    logic [WIDTH-1:0]   fix_res_s;

    // Magnitude of a two's-complement value; -2^(WIDTH-1) maps to 2^(WIDTH-1) unsigned.
    function automatic logic [WIDTH-1:0] abs_val(input logic [WIDTH-1:0] v);
        if (v[WIDTH-1]) begin
            abs_val = ~v + ONE_W;
        end else begin
            abs_val = v;
        end
    endfunction

    // Datapath: add/sub at WIDTH+1 bits, restoring-divide trial step, sign fix-up.
    always_comb begin
        sum_s     = {a_r[WIDTH-1], a_r} + {b_r[WIDTH-1], b_r};
        diff_s    = {a_r[WIDTH-1], a_r} - {b_r[WIDTH-1], b_r};
        abs_a_s   = abs_val(a_r);
        abs_b_s   = abs_val(b_r);
        shifted_s = {rem_r, quot_r[WIDTH-1]};
        fits_s    = (shifted_s >= {1'b0, divisor_r});
        trial_s   = shifted_s[WIDTH-1:0] - divisor_r;
        if (is_div_r) begin
            fix_mag_s = {{WIDTH{1'b0}}, quot_r};
        end else begin
            fix_mag_s = acc_r;
        end
        if (neg_r) begin
            fix_ovf_s = (fix_mag_s > NEG_LIM);
            fix_res_s = ~fix_mag_s[WIDTH-1:0] + ONE_W;
        end else begin
            fix_ovf_s = (fix_mag_s > POS_LIM);
            fix_res_s = fix_mag_s[WIDTH-1:0];
        end
    end

    // Sequencer FSM with registered handshake, result and flags.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r   <= S_IDLE;
            op_r      <= 4'd0;
            a_r       <= ZERO_W;
            b_r       <= ZERO_W;
            neg_r     <= 1'b0;
            is_div_r  <= 1'b0;
            acc_r     <= {(2*WIDTH){1'b0}};
            mcand_r   <= {(2*WIDTH){1'b0}};
            mplier_r  <= ZERO_W;
            divisor_r <= ZERO_W;
            rem_r     <= ZERO_W;
            quot_r    <= ZERO_W;
            iter_r    <= {CW{1'b0}};
            busy      <= 1'b0;
            done      <= 1'b0;
            result    <= ZERO_W;
            ovf       <= 1'b0;
            err       <= 1'b0;
        end else begin
            case (state_r)
                S_IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        op_r    <= opcode;
                        a_r     <= operand_a;
                        b_r     <= operand_b;
                        busy    <= 1'b1;
                        state_r <= S_LOAD;
                    end else begin
                        busy <= 1'b0;
                    end
                end
                S_LOAD: begin
                    case (op_r)
                        OP_ADD, OP_SUB: begin
                            if (op_r == OP_ADD) begin
                                result <= sum_s[WIDTH-1:0];
                                ovf    <= sum_s[WIDTH] ^ sum_s[WIDTH-1];
                            end else begin
                                result <= diff_s[WIDTH-1:0];
                                ovf    <= diff_s[WIDTH] ^ diff_s[WIDTH-1];
                            end
                            err     <= 1'b0;
                            busy    <= 1'b0;
                            done    <= 1'b1;
                            state_r <= S_DONE;
                        end
                        OP_MUL, OP_DIV: begin
                            if ((op_r == OP_DIV) && (b_r == ZERO_W)) begin
                                result  <= ZERO_W;
                                ovf     <= 1'b0;
                                err     <= 1'b1;
                                busy    <= 1'b0;
                                done    <= 1'b1;
                                state_r <= S_DONE;
                            end else begin
                                neg_r     <= a_r[WIDTH-1] ^ b_r[WIDTH-1];
                                is_div_r  <= (op_r == OP_DIV);
                                acc_r     <= {(2*WIDTH){1'b0}};
                                mcand_r   <= {{WIDTH{1'b0}}, abs_a_s};
                                mplier_r  <= abs_b_s;
                                divisor_r <= abs_b_s;
                                rem_r     <= ZERO_W;
                                quot_r    <= abs_a_s;
                                iter_r    <= ITER_INIT;
                                if (op_r == OP_DIV) begin
                                    state_r <= S_DIV_IT;
                                end else begin
                                    state_r <= S_MUL_IT;
                                end
                            end
                        end
                        default: begin
                            result  <= ZERO_W;
                            ovf     <= 1'b0;
                            err     <= 1'b1;
                            busy    <= 1'b0;
                            done    <= 1'b1;
                            state_r <= S_DONE;
                        end
                    endcase
                end
                S_MUL_IT: begin
                    if (mplier_r[0]) begin
                        acc_r <= acc_r + mcand_r;
                    end else begin
                        acc_r <= acc_r;
                    end
                    mcand_r  <= mcand_r << 1;
                    mplier_r <= mplier_r >> 1;
                    iter_r   <= iter_r - ITER_LAST;
                    if (iter_r == ITER_LAST) begin
                        state_r <= S_FIX;
                    end else begin
                        state_r <= S_MUL_IT;
                    end
                end
                S_DIV_IT: begin
                    if (fits_s) begin
                        rem_r  <= trial_s;
                        quot_r <= {quot_r[WIDTH-2:0], 1'b1};
                    end else begin
                        rem_r  <= shifted_s[WIDTH-1:0];
                        quot_r <= {quot_r[WIDTH-2:0], 1'b0};
                    end
                    iter_r <= iter_r - ITER_LAST;
                    if (iter_r == ITER_LAST) begin
                        state_r <= S_FIX;
                    end else begin
                        state_r <= S_DIV_IT;
                    end
                end
                S_FIX: begin
                    result  <= fix_res_s;
                    ovf     <= fix_ovf_s;
                    err     <= 1'b0;
                    busy    <= 1'b0;
                    done    <= 1'b1;
                    state_r <= S_DONE;
                end
                S_DONE: begin
                    done    <= 1'b0;
                    busy    <= 1'b0;
                    state_r <= S_IDLE;
                end
                default: begin
                    busy    <= 1'b0;
                    done    <= 1'b0;
                    state_r <= S_IDLE;
                end
            endcase
        end
    end
endmodule
